// File: rtl/powlib_sdnsizer_pkg.sv
// Shared types and elaboration helpers for the width down-converter.
package powlib_sdnsizer_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  function automatic int powlib_clogb2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/powlib_flipflop.sv
// Register with optional load enable and async active-low clear.
module powlib_flipflop #(
  parameter int W    = 1,
  parameter int EVLD = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic en;

  if (EVLD != 0) begin : g_en
    assign en = vld;
  end else begin : g_free
    assign en = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/powlib_sdnsizer.sv
// Width down-converter: one W-bit word in, up to R narrow beats out, LSB slice first.
module powlib_sdnsizer
  import powlib_sdnsizer_pkg::*;
#(
  parameter int    W    = 32,
  parameter int    R    = 4,
  parameter int    EDBG = 0,
  parameter string ID   = "SDNSIZE"
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [W-1:0]               wrdata,
  input  logic [powlib_clogb2(R)-1:0] wrbeats,
  input  logic                       wrvld,
  output logic                       wrrdy,
  output logic [W/R-1:0]             rddata,
  output logic                       rdlast,
  output logic                       rdvld,
  input  logic                       rdrdy
);

  localparam int BW = powlib_clogb2(R);
  localparam int WO = W / R;

  if (EDBG != 0) begin : g_chk
    if (!is_pow2(R) || R < 2 || (W % R) != 0) begin : g_bad
      $error("%s: illegal parameters W=%0d R=%0d", ID, W, R);
    end
  end

  state_t               state;
  logic [R-1:0][WO-1:0] hold;
  logic [BW-1:0]        lastidx;
  logic [BW-1:0]        idx;
  logic                 load;
  logic                 adv;

  assign rdvld  = (state == SEND);
  assign rdlast = rdvld && (idx == lastidx);
  assign rddata = hold[idx];
  // rdrdy -> wrrdy is the one combinational through-path; it is what makes reload bubble-free.
  assign wrrdy  = rst && ((state == IDLE) || (rdlast && rdrdy));
  assign load   = wrvld && wrrdy;
  assign adv    = rdvld && rdrdy && !rdlast;

  for (genvar g = 0; g < R; g++) begin : g_lane
    powlib_flipflop #(.W(WO), .EVLD(1)) u_hold (
      .clk (clk),
      .rst (rst),
      .vld (load),
      .d   (wrdata[g*WO +: WO]),
      .q   (hold[g])
    );
  end

  powlib_flipflop #(.W(BW), .EVLD(1)) u_lastidx (
    .clk (clk),
    .rst (rst),
    .vld (load),
    .d   (wrbeats),
    .q   (lastidx)
  );

  // idx stops at lastidx, so reload is the only clear it ever needs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      if (load)     idx <= '0;
      else if (adv) idx <= idx + 1'b1;
      case (state)
        IDLE: if (wrvld) state <= SEND;
        SEND: if (rdrdy && rdlast && !wrvld) state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_powlib_sdnsizer.sv
// Directed table plus random stream for powlib_sdnsizer against a beat-queue scoreboard.
module tb_powlib_sdnsizer;

  logic        clk;
  logic        rst;
  logic [31:0] wrdata;
  logic [1:0]  wrbeats;
  logic        wrvld;
  logic        wrrdy;
  logic [7:0]  rddata;
  logic        rdlast;
  logic        rdvld;
  logic        rdrdy;

  powlib_sdnsizer #(.W(32), .R(4), .EDBG(1), .ID("SDNSIZE")) dut (
    .clk     (clk),
    .rst     (rst),
    .wrdata  (wrdata),
    .wrbeats (wrbeats),
    .wrvld   (wrvld),
    .wrrdy   (wrrdy),
    .rddata  (rddata),
    .rdlast  (rdlast),
    .rdvld   (rdvld),
    .rdrdy   (rdrdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  beats;
    logic [31:0] exp;
    int          n;
  } vec_t;

  vec_t       tab [6];
  logic [8:0] sb [$];
  int         vecs = 0;
  int         errs = 0;

  logic       s_rdvld, s_rdlast, s_wrrdy, s_acc;
  logic [7:0] s_rddata;
  logic       stall_prev = 1'b0;
  logic [7:0] st_data;
  logic       st_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called just after a negedge with inputs applied; samples 1 unit before posedge.
  task automatic tick();
    logic [8:0] e;
    #4;
    s_rdvld = rdvld; s_rddata = rddata; s_rdlast = rdlast; s_wrrdy = wrrdy;
    if (stall_prev)
      chk("stall_hold", {rdvld, rdlast, rddata}, {1'b1, st_last, st_data});
    if (rst && rdvld && rdrdy) begin
      if (sb.size() == 0) begin
        vecs++; errs++;
        $display("FAIL spurious_beat: got %0h want no beat at %0t", rddata, $time);
      end else begin
        e = sb.pop_front();
        chk("beat_stream", {rdlast, rddata}, e);
      end
    end
    stall_prev = rst && rdvld && !rdrdy;
    st_data = rddata; st_last = rdlast;
    s_acc = rst && wrvld && wrrdy;
    if (s_acc)
      for (int i = 0; i <= int'(wrbeats); i++)
        sb.push_back({i == int'(wrbeats), wrdata[8*i +: 8]});
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ev;
    tab[0] = '{32'hDDCCBBAA, 2'd3, 32'hDDCCBBAA, 4};
    tab[1] = '{32'h04030201, 2'd3, 32'h04030201, 4};
    tab[2] = '{32'h08070605, 2'd3, 32'h08070605, 4};
    tab[3] = '{32'hEEFFC311, 2'd0, 32'h00000011, 1};
    tab[4] = '{32'h99882322, 2'd1, 32'h00002322, 2};
    tab[5] = '{32'h77665544, 2'd2, 32'h00665544, 3};

    rst = 1'b0; wrvld = 1'b0; wrdata = '0; wrbeats = '0; rdrdy = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_outputs", {rdvld, rdlast, rddata, wrrdy}, 11'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("idle_wrrdy", {s_rdvld, s_wrrdy}, 2'b01);

    // Table: words streamed back-to-back with wrvld held, rdrdy high.
    rdrdy = 1'b1; wrvld = 1'b1; wrdata = tab[0].data; wrbeats = tab[0].beats;
    tick();
    chk("accept_cycle", {s_rdvld, s_wrrdy}, 2'b01);
    for (int r = 0; r < 6; r++) begin
      if (r < 5) begin
        wrdata = tab[r+1].data; wrbeats = tab[r+1].beats;
      end else begin
        wrvld = 1'b0; wrdata = $urandom;
      end
      ev = tab[r].exp;
      for (int b = 0; b < tab[r].n; b++) begin
        tick();
        chk("tbl_vld", 64'(s_rdvld), 64'd1);
        chk("tbl_data", 64'(s_rddata), 64'(ev[8*b +: 8]));
        chk("tbl_last", 64'(s_rdlast), 64'(b == tab[r].n - 1));
        chk("tbl_wrrdy", 64'(s_wrrdy), 64'(b == tab[r].n - 1));
      end
    end
    tick();
    chk("tbl_idle", 64'(s_rdvld), 64'd0);

    // Stall pattern on a full word.
    wrvld = 1'b1; wrdata = 32'hDDCCBBAA; wrbeats = 2'd3; rdrdy = 1'b1;
    tick();
    wrvld = 1'b0;
    foreach (tab[i]) begin
      rdrdy = tab[i].n[0] ^ i[0];
      tick();
    end
    rdrdy = 1'b0; tick(); tick();
    rdrdy = 1'b1;
    for (int k = 0; k < 8 && sb.size() != 0; k++) tick();
    chk("stall_drain", 64'(sb.size()), 64'd0);

    // Reset mid-word after beat BB.
    tick();
    wrvld = 1'b1; wrdata = 32'hDDCCBBAA; wrbeats = 2'd3;
    tick();
    wrvld = 1'b0;
    tick();
    tick();
    chk("pre_rst_bb", 64'(s_rddata), 64'hBB);
    rst = 1'b0;
    #1;
    chk("rst_async", {rdvld, wrrdy, rdlast, rddata}, 11'h0);
    sb.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_idle", {s_rdvld, s_wrrdy}, 2'b01);
    end

    // Random words and backpressure against the scoreboard.
    s_acc = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!wrvld || s_acc) begin
        wrvld   = ($urandom_range(0, 9) < 7);
        wrdata  = $urandom;
        wrbeats = 2'($urandom_range(0, 3));
      end
      rdrdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    wrvld = 1'b0; rdrdy = 1'b1;
    for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
    chk("final_drain", 64'(sb.size()), 64'd0);
    tick();
    chk("final_idle", 64'(s_rdvld), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
